// File: rtl/result_bcd_converter.sv
// result_bcd_converter: 32-bit binary to 10-digit packed BCD using double-dabble.
// Defining CALC_SIGNED_EN treats value as two's complement and reports its sign on neg.
module result_bcd_converter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd,
    output logic        neg
);
    typedef enum logic {IDLE, CONVERT} state_t;
    state_t      state;
    logic [5:0]  count;
    logic [31:0] bin;
    logic [31:0] operand;
    logic [39:0] work;
    logic [39:0] adj;
    logic [39:0] next_work;
    always_comb begin
        adj = work;
        for (int d = 0; d < 10; d++)
            adj[4*d +: 4] = work[4*d +: 4] >= 4'd5 ? work[4*d +: 4] + 4'd3 : work[4*d +: 4];
        next_work = (adj << 1) | {39'd0, bin[31]};
    end
`ifdef CALC_SIGNED_EN
    logic sign;
    assign operand = value[31] ? ~value + 32'd1 : value;
`else
    assign operand = value;
    assign neg     = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            bin   <= '0;
            work  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
`ifdef CALC_SIGNED_EN
            sign  <= 1'b0;
            neg   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= CONVERT;
                    busy  <= 1'b1;
                    bin   <= operand;
                    work  <= '0;
                    count <= '0;
`ifdef CALC_SIGNED_EN
                    sign  <= value[31];
`endif
                end
                CONVERT: begin
                    work  <= next_work;
                    bin   <= bin << 1;
                    count <= count + 6'd1;
                    // the 32nd shift lands directly in bcd so partial sums never show
                    if (count == 6'd31) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= next_work;
`ifdef CALC_SIGNED_EN
                        neg   <= sign;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: directed bench with a decimal-arithmetic reference model.
module tb_result_bcd_converter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic        busy, done, neg;
    logic [39:0] bcd;
    int compared = 0;
    int mismatched = 0;

    result_bcd_converter dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .bcd(bcd), .neg(neg)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] to_bcd(input longint unsigned n);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // reference: countdown of cycles left, result produced by decimal arithmetic
    logic            m_busy = 0, m_done = 0, m_neg = 0, m_sgn = 0;
    logic [39:0]     m_bcd = '0;
    longint unsigned m_mag = 0;
    int              left = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_bcd = '0; m_neg = 0; left = 0;
        end else begin
            m_done = 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_busy = 0; m_done = 1; m_bcd = to_bcd(m_mag); m_neg = m_sgn;
                end
            end else if (start) begin
                left = 32; m_busy = 1;
`ifdef CALC_SIGNED_EN
                m_sgn = value[31];
                m_mag = value[31] ? 64'h1_0000_0000 - longint'(value) : longint'(value);
`else
                m_sgn = 0;
                m_mag = longint'(value);
`endif
            end
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", {39'd0, busy}, {39'd0, m_busy});
        check("done", {39'd0, done}, {39'd0, m_done});
        check("bcd", bcd, m_bcd);
        check("neg", {39'd0, neg}, {39'd0, m_neg});
    end

    task automatic pulse(input logic [31:0] v);
        @(negedge clk);
        value = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL timeout: done never rose");
        end
    endtask

    task automatic run(input logic [31:0] v, input logic [39:0] exp_bcd, input logic exp_neg);
        int n;
        pulse(v);
        wait_done(n);
        check("lit_bcd", bcd, exp_bcd);
        check("lit_neg", {39'd0, neg}, {39'd0, exp_neg});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_bcd", bcd, 40'h0);
        check("reset_busy", {39'd0, busy}, 40'h0);
        reset = 1'b0;

        pulse(32'd0);
        wait_done(n);
        check("busy_cycles", 40'(n), 40'd32);
        check("zero_bcd", bcd, 40'h0000000000);

        pulse(32'd12345);
        repeat (10) @(negedge clk);
        check("bcd_held", bcd, 40'h0000000000);
        wait_done(n);
        check("bcd_12345", bcd, 40'h0000012345);
        @(negedge clk);
        check("done_one_cycle", {39'd0, done}, 40'h0);

`ifdef CALC_SIGNED_EN
        run(32'hFFFFFFFF, 40'h0000000001, 1'b1);
`else
        run(32'hFFFFFFFF, 40'h4294967295, 1'b0);
`endif
`ifdef CALC_SIGNED_EN
        run(32'h80000000, 40'h2147483648, 1'b1);
`else
        run(32'h80000000, 40'h2147483648, 1'b0);
`endif
        run(32'd99999999, 40'h0099999999, 1'b0);
        run(32'd1000000000, 40'h1000000000, 1'b0);

        // start while busy is ignored, then restart in the done cycle
        pulse(32'd100);
        repeat (3) @(negedge clk);
        value = 32'd999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("busy_ignore", bcd, 40'h0000000100);
        value = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("no_double_done", {39'd0, done}, 40'h0);
        wait_done(n);
        check("done_cycle_start", bcd, 40'h0000000007);
        check("restart_busy", 40'(n), 40'd32);

        // asynchronous abort
        pulse(32'd555);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {39'd0, busy}, 40'h0);
        check("abort_bcd", bcd, 40'h0);
        check("abort_neg", {39'd0, neg}, 40'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check("abort_no_done", {39'd0, done}, 40'h0);
        end
        run(32'd42, 40'h0000000042, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
